// File: rtl/lutram_cam_pkg.sv
// Shared constants and types for the LUTRAM-based CAM block.
package lutram_cam_pkg;

    localparam int CHUNK_W   = 6;
    localparam int ROW_DEPTH = 64;

    typedef enum logic {
        UPD_WRITE = 1'b0,
        UPD_INVAL = 1'b1
    } upd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

endpackage

// File: rtl/lutram.sv
// Distributed RAM primitive: synchronous write, asynchronous read, no reset.
module lutram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Write port; the contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/lutram_cam_prio_enc.sv
// Lowest-index priority encoder with a multiple-match flag.
module lutram_cam_prio_enc #(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] mvec,
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic               multi
);

    // The first set bit gives the index; any further set bit flags a multi-match.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        multi = 1'b0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (mvec[e]) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    hit = 1'b1;
                    idx = IDX_W'(e);
                end
            end
        end
    end

endmodule

// File: rtl/lutram_cam_block.sv
// LUTRAM binary CAM: one 64 x ENTRIES lutram per 6-bit key chunk, a two-stage
// search pipeline and a 64-cycle row-sweeping update engine.
module lutram_cam_block
    import lutram_cam_pkg::*;
#(
    parameter int KEY_WIDTH = 24,
    parameter int ENTRIES   = 32,
    parameter int IDX_W     = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 srch_valid,
    output logic                 srch_ready,
    input  logic [KEY_WIDTH-1:0] srch_key,
    output logic                 rslt_valid,
    output logic                 rslt_hit,
    output logic                 rslt_multi,
    output logic [IDX_W-1:0]     rslt_idx,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic                 upd_op,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic [KEY_WIDTH-1:0] upd_key,
    output logic                 upd_done
);

    localparam int NCHUNK = KEY_WIDTH / CHUNK_W;
    localparam logic [CHUNK_W-1:0] LAST_ROW = CHUNK_W'(ROW_DEPTH - 1);

    if (KEY_WIDTH % CHUNK_W != 0 || KEY_WIDTH == 0) begin : g_bad_key_width
        $error("lutram_cam_block: KEY_WIDTH must be a non-zero multiple of 6");
    end
    if (ENTRIES < 2 || ENTRIES > 64 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("lutram_cam_block: ENTRIES must be a power of 2 from 2 to 64");
    end

    state_e                         state;
    state_e                         state_next;
    logic [CHUNK_W-1:0]             cnt;
    logic [IDX_W-1:0]               wr_idx;
    logic [KEY_WIDTH-1:0]           wr_key;
    logic [ENTRIES-1:0]             valid;
    logic [NCHUNK-1:0][ENTRIES-1:0] rows;
    logic [ENTRIES-1:0]             match_now;
    logic [ENTRIES-1:0]             mvec;
    logic                           s1_valid;
    logic                           enc_hit;
    logic                           enc_multi;
    logic [IDX_W-1:0]               enc_idx;
    logic                           srch_accept;
    logic                           upd_accept;

    assign srch_accept = srch_valid && srch_ready;
    assign upd_accept  = upd_valid && upd_ready;

    // One lutram per chunk; the address sweeps rows while writing, else follows the search key.
    for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
        logic [CHUNK_W-1:0] addr;
        logic [ENTRIES-1:0] wdata;

        assign addr = (state == ST_WRITE) ? cnt : srch_key[c*CHUNK_W +: CHUNK_W];

        // Read-modify-write of the current row: only the target entry's bit changes.
        always_comb begin
            wdata         = rows[c];
            wdata[wr_idx] = (cnt == wr_key[c*CHUNK_W +: CHUNK_W]);
        end

        lutram #(
            .WIDTH  (ENTRIES),
            .ADDR_W (CHUNK_W)
        ) u_lutram (
            .clk  (clk),
            .wen  (state == ST_WRITE),
            .addr (addr),
            .din  (wdata),
            .dout (rows[c])
        );
    end

    // An entry matches only if every chunk row has its bit set and it is valid.
    always_comb begin
        match_now = valid;
        for (int c = 0; c < NCHUNK; c++) begin
            match_now = match_now & rows[c];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshakes; updates win over searches, nothing is accepted in reset.
    always_comb begin
        state_next = state;
        upd_ready  = 1'b0;
        srch_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                upd_ready  = !rst;
                srch_ready = !rst && !upd_valid;
                if (upd_accept && upd_op_e'(upd_op) == UPD_WRITE) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt == LAST_ROW) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Update engine: valid bits, row counter, latched target and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            cnt      <= '0;
            wr_idx   <= '0;
            wr_key   <= '0;
            upd_done <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            if (state == ST_IDLE) begin
                cnt <= '0;
                if (upd_accept) begin
                    valid[upd_idx] <= 1'b0;
                    if (upd_op_e'(upd_op) == UPD_INVAL) begin
                        upd_done <= 1'b1;
                    end else begin
                        wr_idx <= upd_idx;
                        wr_key <= upd_key;
                    end
                end
            end else begin
                cnt <= cnt + CHUNK_W'(1);
                if (cnt == LAST_ROW) begin
                    valid[wr_idx] <= 1'b1;
                    upd_done      <= 1'b1;
                end
            end
        end
    end

    lutram_cam_prio_enc #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .mvec  (mvec),
        .hit   (enc_hit),
        .idx   (enc_idx),
        .multi (enc_multi)
    );

    // Search pipeline: S1 captures the match vector, S2 captures the encoded result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mvec       <= '0;
            s1_valid   <= 1'b0;
            rslt_valid <= 1'b0;
            rslt_hit   <= 1'b0;
            rslt_multi <= 1'b0;
            rslt_idx   <= '0;
        end else begin
            mvec       <= srch_accept ? match_now : '0;
            s1_valid   <= srch_accept;
            rslt_valid <= s1_valid;
            rslt_hit   <= s1_valid && enc_hit;
            rslt_multi <= s1_valid && enc_multi;
            rslt_idx   <= s1_valid ? enc_idx : '0;
        end
    end

endmodule

// File: tb/tb_lutram_cam_block.sv
// Directed self-checking bench for lutram_cam_block.
module tb_lutram_cam_block;

    localparam int KEY_WIDTH = 24;
    localparam int ENTRIES   = 32;
    localparam int IDX_W     = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 srch_valid;
    logic                 srch_ready;
    logic [KEY_WIDTH-1:0] srch_key;
    logic                 rslt_valid;
    logic                 rslt_hit;
    logic                 rslt_multi;
    logic [IDX_W-1:0]     rslt_idx;
    logic                 upd_valid;
    logic                 upd_ready;
    logic                 upd_op;
    logic [IDX_W-1:0]     upd_idx;
    logic [KEY_WIDTH-1:0] upd_key;
    logic                 upd_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [KEY_WIDTH-1:0] key;
        logic                 hit;
        int                   idx;
        logic                 multi;
    } vec_t;

    vec_t vecs [5];

    lutram_cam_block #(
        .KEY_WIDTH (KEY_WIDTH),
        .ENTRIES   (ENTRIES),
        .IDX_W     (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .srch_valid (srch_valid),
        .srch_ready (srch_ready),
        .srch_key   (srch_key),
        .rslt_valid (rslt_valid),
        .rslt_hit   (rslt_hit),
        .rslt_multi (rslt_multi),
        .rslt_idx   (rslt_idx),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_op     (upd_op),
        .upd_idx    (upd_idx),
        .upd_key    (upd_key),
        .upd_done   (upd_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResult(input string name, input logic h, input int idx, input logic m);
        checkOutput({name, "_valid"}, 32'(rslt_valid), 32'd1);
        checkOutput({name, "_hit"},   32'(rslt_hit),   32'(h));
        checkOutput({name, "_idx"},   32'(rslt_idx),   32'(idx));
        checkOutput({name, "_multi"}, 32'(rslt_multi), 32'(m));
    endtask

    task automatic searchOne(input logic [KEY_WIDTH-1:0] key, input logic h, input int idx,
                             input logic m, input string name);
        srch_valid = 1'b1;
        srch_key   = key;
        #1;
        checkOutput({name, "_srch_ready"}, 32'(srch_ready), 32'd1);
        step();
        srch_valid = 1'b0;
        checkOutput({name, "_latency"}, 32'(rslt_valid), 32'd0);
        step();
        checkResult(name, h, idx, m);
    endtask

    // Starts in the first cycle after a WRITE accept and ends in the cycle after upd_done.
    task automatic waitWriteDone(input string name);
        int bad = 0;
        for (int k = 1; k <= 64; k++) begin
            if (upd_ready || srch_ready || upd_done || (k >= 2 && rslt_valid)) bad++;
            step();
        end
        checkOutput({name, "_busy"},  32'(bad),       32'd0);
        checkOutput({name, "_done"},  32'(upd_done),  32'd1);
        checkOutput({name, "_ready"}, 32'(upd_ready), 32'd1);
        step();
        checkOutput({name, "_done_pulse"}, 32'(upd_done), 32'd0);
    endtask

    task automatic updateOne(input logic op, input int idx, input logic [KEY_WIDTH-1:0] key,
                             input string name);
        upd_valid = 1'b1;
        upd_op    = op;
        upd_idx   = IDX_W'(idx);
        upd_key   = key;
        #1;
        checkOutput({name, "_upd_ready"}, 32'(upd_ready), 32'd1);
        step();
        upd_valid = 1'b0;
        if (op == 1'b0) begin
            waitWriteDone(name);
        end else begin
            checkOutput({name, "_inv_done"}, 32'(upd_done), 32'd1);
            step();
            checkOutput({name, "_inv_done_pulse"}, 32'(upd_done), 32'd0);
        end
    endtask

    // Issues the vector table back to back, one key per cycle, and checks results in order.
    task automatic applyStimulus();
        int n = $size(vecs);
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) checkResult($sformatf("pipe%0d", i - 2), vecs[i-2].hit, vecs[i-2].idx, vecs[i-2].multi);
            if (i < n) begin
                srch_valid = 1'b1;
                srch_key   = vecs[i].key;
            end else begin
                srch_valid = 1'b0;
            end
            step();
        end
        checkOutput("pipe_drain", 32'(rslt_valid), 32'd0);
    endtask

    initial begin
        int cnt_done;
        vecs[0] = '{24'hABCDEF, 1'b0, 0, 1'b0};
        vecs[1] = '{24'h111111, 1'b1, 5, 1'b0};
        vecs[2] = '{24'h000001, 1'b1, 9, 1'b0};
        vecs[3] = '{24'hABCDEE, 1'b0, 0, 1'b0};
        vecs[4] = '{24'h000000, 1'b0, 0, 1'b0};

        rst        = 1'b1;
        srch_valid = 1'b0;
        srch_key   = '0;
        upd_valid  = 1'b0;
        upd_op     = 1'b0;
        upd_idx    = '0;
        upd_key    = '0;
        repeat (3) step();
        checkOutput("rst_rslt_valid", 32'(rslt_valid), 32'd0);
        checkOutput("rst_upd_done",   32'(upd_done),   32'd0);
        checkOutput("rst_srch_ready", 32'(srch_ready), 32'd0);
        checkOutput("rst_upd_ready",  32'(upd_ready),  32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_srch_ready", 32'(srch_ready), 32'd1);
        checkOutput("post_rst_upd_ready",  32'(upd_ready),  32'd1);
        step();

        searchOne(24'h123456, 1'b0, 0, 1'b0, "empty");

        updateOne(1'b0, 5, 24'hABCDEF, "wr5");
        searchOne(24'hABCDEF, 1'b1, 5, 1'b0, "hit5");
        searchOne(24'hABCDEE, 1'b0, 0, 1'b0, "miss5");

        updateOne(1'b0, 3, 24'h000001, "wr3");
        updateOne(1'b0, 9, 24'h000001, "wr9");
        searchOne(24'h000001, 1'b1, 3, 1'b1, "dup");
        updateOne(1'b1, 3, 24'h0, "inv3");
        searchOne(24'h000001, 1'b1, 9, 1'b0, "after_inv");

        updateOne(1'b0, 5, 24'h111111, "ovr5");
        applyStimulus();

        // Search one cycle before a simultaneous search+update request.
        srch_valid = 1'b1;
        srch_key   = 24'h111111;
        step();
        upd_valid = 1'b1;
        upd_op    = 1'b0;
        upd_idx   = IDX_W'(5);
        upd_key   = 24'h222222;
        #1;
        checkOutput("both_srch_ready", 32'(srch_ready), 32'd0);
        checkOutput("both_upd_ready",  32'(upd_ready),  32'd1);
        step();
        srch_valid = 1'b0;
        upd_valid  = 1'b0;
        checkResult("old_result", 1'b1, 5, 1'b0);
        waitWriteDone("both");
        searchOne(24'h222222, 1'b1, 5, 1'b0, "new5");
        searchOne(24'h111111, 1'b0, 0, 1'b0, "old5");

        // Reset in the middle of a WRITE to entry 7.
        upd_valid = 1'b1;
        upd_op    = 1'b0;
        upd_idx   = IDX_W'(7);
        upd_key   = 24'h333333;
        step();
        upd_valid = 1'b0;
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("abort_idle", 32'(upd_ready), 32'd1);
        cnt_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (upd_done) cnt_done++;
            step();
        end
        checkOutput("abort_no_done", 32'(cnt_done), 32'd0);
        searchOne(24'h333333, 1'b0, 0, 1'b0, "abort_miss");
        searchOne(24'h000001, 1'b0, 0, 1'b0, "rst_cleared");
        updateOne(1'b0, 7, 24'h333333, "wr7");
        searchOne(24'h333333, 1'b1, 7, 1'b0, "hit7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
